// File: rtl/game_timer.sv
// game_timer: level countdown timer for the HUD, game-over and sound cue logic.
// Counts whole seconds down from a loadable start value at TICKS_PER_SEC
// vga_clock cycles per second, with pause, saturating bonus-time addition,
// a low-time warning flag and BCD digits of the current count.
module game_timer #(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int START_SECONDS = 25,
  parameter int MAX_SECONDS   = 999,
  parameter int WARN_SECONDS  = 10,
  parameter int SEC_W         = 10
) (
  input  logic             vga_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             add,
  input  logic [SEC_W-1:0] add_amount,
  output logic [SEC_W-1:0] seconds,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             running,
  output logic             warning,
  output logic             sec_pulse,
  output logic             expired_pulse,
  output logic             done
);

  // Tick counter spans 0..TICKS_PER_SEC-1; one bit minimum keeps the
  // declaration legal for the smallest allowed rate of 2.
  localparam int TICK_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]  MAX_SEC   = SEC_W'(MAX_SECONDS);
  localparam logic [SEC_W:0]    MAX_EXT   = (SEC_W + 1)'(MAX_SECONDS);
  localparam logic [SEC_W-1:0]  START_SEC = SEC_W'(START_SECONDS);
  localparam logic [SEC_W-1:0]  WARN_SEC  = SEC_W'(WARN_SECONDS);
  localparam logic [SEC_W:0]    ONE_EXT   = (SEC_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t              state_reg;
  logic [SEC_W-1:0]    seconds_reg;
  logic [TICK_W-1:0]   tick_reg;
  logic                sec_pulse_reg;
  logic                expired_pulse_reg;

  // Arithmetic helpers: all sums carry one extra bit so saturation sees
  // the true result before it is clipped to MAX_SECONDS.
  logic [SEC_W:0]      sum_ext;
  logic [SEC_W:0]      dec_ext;
  logic [SEC_W-1:0]    add_sat;
  logic [SEC_W-1:0]    dec_sat;
  logic [SEC_W-1:0]    sec_after_add;
  logic [SEC_W-1:0]    load_sat;
  logic                tick_wrap;
  logic                dec_ok;

  // Next-value arithmetic for add, decrement (with coincident add) and load.
  always_comb begin
    sum_ext       = {1'b0, seconds_reg} + {1'b0, add_amount};
    add_sat       = (sum_ext > MAX_EXT) ? MAX_SEC : sum_ext[SEC_W-1:0];
    sec_after_add = add ? add_sat : seconds_reg;

    // Decrement and bonus land on the same edge as a single combined update:
    // seconds - 1 + add_amount, saturated afterwards.
    if (add) begin
      dec_ext = sum_ext - ONE_EXT;
    end else begin
      dec_ext = {1'b0, seconds_reg} - ONE_EXT;
    end
    dec_sat   = (dec_ext > MAX_EXT) ? MAX_SEC : dec_ext[SEC_W-1:0];

    load_sat  = (load_value > MAX_SEC) ? MAX_SEC : load_value;
    tick_wrap = (tick_reg == TICK_LAST);
    // Never decrement below zero, even if RUNNING were somehow reached at 0.
    dec_ok    = (seconds_reg != '0);
  end

  // Timer state machine: reset > load > per-state start/pause/tick/add.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      seconds_reg       <= START_SEC;
      tick_reg          <= '0;
      sec_pulse_reg     <= 1'b0;
      expired_pulse_reg <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless re-armed below.
      sec_pulse_reg     <= 1'b0;
      expired_pulse_reg <= 1'b0;

      if (load) begin
        state_reg   <= IDLE;
        seconds_reg <= load_sat;
        tick_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            tick_reg    <= '0;
            seconds_reg <= sec_after_add;
            if (start) begin
              if (sec_after_add != '0) begin
                state_reg <= RUNNING;
              end else begin
                // Starting with nothing on the clock expires immediately.
                state_reg         <= EXPIRED;
                expired_pulse_reg <= 1'b1;
              end
            end
          end

          RUNNING: begin
            if (pause) begin
              // Tick is held exactly where it was so the period resumes intact.
              state_reg   <= PAUSED;
              seconds_reg <= sec_after_add;
            end else if (tick_wrap && dec_ok) begin
              tick_reg      <= '0;
              seconds_reg   <= dec_sat;
              sec_pulse_reg <= 1'b1;
              // A coincident bonus can rescue the final second.
              if (dec_sat == '0) begin
                state_reg         <= EXPIRED;
                expired_pulse_reg <= 1'b1;
              end
            end else begin
              tick_reg    <= tick_wrap ? '0 : tick_reg + 1'b1;
              seconds_reg <= sec_after_add;
            end
          end

          PAUSED: begin
            seconds_reg <= sec_after_add;
            if (!pause) begin
              state_reg <= RUNNING;
            end
          end

          EXPIRED: begin
            // Bonus time is ignored once the level clock has run out.
            seconds_reg <= '0;
            tick_reg    <= '0;
          end

          default: begin
            state_reg <= IDLE;
            tick_reg  <= '0;
          end
        endcase
      end
    end
  end

  // Binary-to-BCD by shift-and-add-3 over the seconds register.
  logic [SEC_W+11:0] dd;

  always_comb begin
    dd             = '0;
    dd[SEC_W-1:0]  = seconds_reg;
    for (int i = 0; i < SEC_W; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (dd[SEC_W + 4*d +: 4] >= 4'd5) begin
          dd[SEC_W + 4*d +: 4] = dd[SEC_W + 4*d +: 4] + 4'd3;
        end
      end
      dd = dd << 1;
    end
  end

  assign bcd_ones     = dd[SEC_W     +: 4];
  assign bcd_tens     = dd[SEC_W + 4 +: 4];
  assign bcd_hundreds = dd[SEC_W + 8 +: 4];

  // Status outputs decoded from registered state.
  assign seconds       = seconds_reg;
  assign running       = (state_reg == RUNNING);
  assign done          = (state_reg == EXPIRED);
  assign sec_pulse     = sec_pulse_reg;
  assign expired_pulse = expired_pulse_reg;
  assign warning       = (state_reg != EXPIRED) && (seconds_reg != '0) &&
                         (seconds_reg <= WARN_SEC);

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed sequence against game_timer with a 4-cycle second,
// start value 3 and warning threshold 2. Expectations are queued as each step
// is driven and compared against a snapshot of all outputs after the edge.
module tb_game_timer;

  localparam int SEC_W = 11;

  logic             vga_clock = 1'b0;
  logic             reset     = 1'b1;
  logic             start     = 1'b0;
  logic             pause     = 1'b0;
  logic             load      = 1'b0;
  logic             add       = 1'b0;
  logic [SEC_W-1:0] load_value = '0;
  logic [SEC_W-1:0] add_amount = '0;

  logic [SEC_W-1:0] seconds;
  logic [3:0]       bcd_hundreds, bcd_tens, bcd_ones;
  logic             running, warning, sec_pulse, expired_pulse, done;

  game_timer #(
    .TICKS_PER_SEC(4),
    .START_SECONDS(3),
    .MAX_SECONDS  (999),
    .WARN_SECONDS (2),
    .SEC_W        (SEC_W)
  ) dut (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .load         (load),
    .load_value   (load_value),
    .add          (add),
    .add_amount   (add_amount),
    .seconds      (seconds),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .running      (running),
    .warning      (warning),
    .sec_pulse    (sec_pulse),
    .expired_pulse(expired_pulse),
    .done         (done)
  );

  always #5 vga_clock = ~vga_clock;

  // Snapshot layout: seconds, running, done, sec_pulse, expired_pulse,
  // warning, hundreds, tens, ones.
  typedef struct {
    string       tag;
    logic [27:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   steps  = 0;

  function automatic logic [27:0] pack(input int sec, input bit run, input bit dn,
                                       input bit sp, input bit ep);
    bit warn;
    warn = !dn && (sec != 0) && (sec <= 2);
    return {11'(sec), run, dn, sp, ep, warn,
            4'(sec / 100), 4'((sec / 10) % 10), 4'(sec % 10)};
  endfunction

  // One clock edge: queue the expectation, let the edge happen, compare at negedge.
  task automatic step(input string tag, input int sec, input bit run, input bit dn,
                      input bit sp, input bit ep);
    exp_t        e;
    logic [27:0] obs;
    sb.push_back('{tag, pack(sec, run, dn, sp, ep)});
    @(posedge vga_clock);
    @(negedge vga_clock);
    e   = sb.pop_front();
    obs = {seconds, running, done, sec_pulse, expired_pulse, warning,
           bcd_hundreds, bcd_tens, bcd_ones};
    checks++;
    steps++;
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
    end
    $display("step %0d %s sec=%0d run=%0b done=%0b sp=%0b ep=%0b warn=%0b",
             steps, e.tag, seconds, running, done, sec_pulse, expired_pulse, warning);
  endtask

  initial begin
    // Reset, then a full countdown 3,2,1,0.
    reset = 1'b1;
    step("reset", 3, 0, 0, 0, 0);
    reset = 1'b0; start = 1'b1;
    step("start", 3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("run3", 3, 1, 0, 0, 0);
    step("dec_to_2", 2, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("run2", 2, 1, 0, 0, 0);
    step("dec_to_1", 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("run1", 1, 1, 0, 0, 0);
    step("expire", 0, 0, 1, 1, 1);
    step("expired_hold", 0, 0, 1, 0, 0);
    start = 1'b0;
    step("expired_hold2", 0, 0, 1, 0, 0);

    // Pause after two ticks of a period, with a bonus second while paused.
    reset = 1'b1;
    step("reset2", 3, 0, 0, 0, 0);
    reset = 1'b0; start = 1'b1;
    step("start2", 3, 1, 0, 0, 0);
    step("tick1", 3, 1, 0, 0, 0);
    step("tick2", 3, 1, 0, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      add        = (i == 4);
      add_amount = 11'd1;
      step("paused", (i >= 4) ? 4 : 3, 0, 0, 0, 0);
    end
    add = 1'b0; pause = 1'b0;
    step("resume", 4, 1, 0, 0, 0);
    step("resume_tick3", 4, 1, 0, 0, 0);
    step("resume_dec", 3, 1, 0, 1, 0);

    // Run down to the last second, then add on the 1->0 edge.
    for (int i = 0; i < 3; i++) step("run3b", 3, 1, 0, 0, 0);
    step("dec_to_2b", 2, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("run2b", 2, 1, 0, 0, 0);
    step("dec_to_1b", 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("run1b", 1, 1, 0, 0, 0);
    add = 1'b1; add_amount = 11'd7;
    step("add_on_zero", 7, 1, 0, 1, 0);
    add_amount = 11'd2;
    step("add_running", 9, 1, 0, 0, 0);
    add = 1'b0;
    step("run9", 9, 1, 0, 0, 0);

    // Load saturation and BCD digits.
    start = 1'b0;
    load = 1'b1; load_value = 11'd1500;
    step("load_sat", 999, 0, 0, 0, 0);
    load = 1'b0; add = 1'b1; add_amount = 11'd5;
    step("add_sat", 999, 0, 0, 0, 0);
    add_amount = 11'd2047;
    step("add_sat_max", 999, 0, 0, 0, 0);
    add = 1'b0; load = 1'b1; load_value = 11'd407;
    step("load_407", 407, 0, 0, 0, 0);
    load_value = 11'd58;
    step("load_58", 58, 0, 0, 0, 0);
    load = 1'b0; add = 1'b1; add_amount = 11'd3;
    step("add_idle", 61, 0, 0, 0, 0);
    add = 1'b0;

    // Load 0 then start: immediate expiry; add is ignored afterwards.
    load = 1'b1; load_value = 11'd0;
    step("load_zero", 0, 0, 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step("start_zero", 0, 0, 1, 0, 1);
    start = 1'b0; add = 1'b1; add_amount = 11'd9;
    step("add_expired", 0, 0, 1, 0, 0);
    add = 1'b0; load = 1'b1; load_value = 11'd5;
    step("load_from_exp", 5, 0, 0, 0, 0);
    load = 1'b0;

    // Reset mid-run at seconds=2, on the edge that would decrement.
    reset = 1'b1;
    step("reset3", 3, 0, 0, 0, 0);
    reset = 1'b0; start = 1'b1;
    step("start3", 3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("run3c", 3, 1, 0, 0, 0);
    step("dec_to_2c", 2, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("run2c", 2, 1, 0, 0, 0);
    reset = 1'b1;
    step("reset_mid", 3, 0, 0, 0, 0);
    load = 1'b1; load_value = 11'd50;
    step("reset_vs_load", 3, 0, 0, 0, 0);
    reset = 1'b0; load = 1'b0; start = 1'b0;
    step("idle_after", 3, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
